// File: rtl/timer_share_sched.sv
// timer_share_sched: round-robin scheduler sharing one Avalon-MM interval timer among N requesters.
// Build macro TIMER_SHARE_SCHED_CANCEL_EN: an owner dropping req in WAIT/GAP aborts and pulses cancelled.
module timer_share_sched #(
   parameter int N  = 4,
   parameter int TW = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N-1:0]    req,
   input  logic [N*TW-1:0] ticks,
   output logic [N-1:0]    grant,
   output logic [N-1:0]    done,
   output logic            busy,
   output logic [2:0]      tmr_address,
   output logic            tmr_chipselect,
   output logic            tmr_write_n,
   output logic [15:0]     tmr_writedata,
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
   output logic            cancelled,
`endif
   input  logic            tmr_irq
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   localparam logic [2:0]  REG_STATUS  = 3'd0;
   localparam logic [2:0]  REG_CONTROL = 3'd1;
   localparam logic [15:0] CTRL_START  = 16'h0007;
   localparam logic [15:0] CTRL_STOP   = 16'h0008;
   localparam logic [15:0] STATUS_CLR  = 16'h0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_START,
      S_WAIT,
      S_ACK,
      S_GAP,
      S_STOP,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [PW-1:0] rr_ptr, rr_ptr_nx;
   logic [PW-1:0] owner, owner_nx;
   logic [PW-1:0] pick, cand;
   logic          pick_valid;
   logic [TW-1:0] pick_ticks;
   logic [TW-1:0] cnt, cnt_nx;
   logic [TW-1:0] cnt_target, cnt_target_nx;
   logic [N-1:0]  grant_nx, done_nx;
   logic          chipselect_nx, write_n_nx;
   logic [2:0]    address_nx;
   logic [15:0]   writedata_nx;
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
   logic          abort, abort_nx, cancelled_nx;
   logic          owner_dropped;

   assign owner_dropped = !req[owner];
`endif

   // First pending requester at or after the round-robin pointer, wrapping.
   always_comb begin
      pick       = '0;
      cand       = '0;
      pick_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand = PW'((int'(rr_ptr) + i) % N);
         if (!pick_valid && req[cand]) begin
            pick       = cand;
            pick_valid = 1'b1;
         end
      end
   end

   assign pick_ticks = ticks[int'(pick)*TW +: TW];

   always_comb begin
      state_nx      = state;
      rr_ptr_nx     = rr_ptr;
      owner_nx      = owner;
      cnt_nx        = cnt;
      cnt_target_nx = cnt_target;
      grant_nx      = grant;
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
      abort_nx      = abort;
`endif
      case (state)
         S_IDLE: begin
            if (|req) state_nx = S_ARB;
         end
         S_ARB: begin
            // A request withdrawn before arbitration simply returns to IDLE.
            if (!pick_valid) begin
               state_nx = S_IDLE;
            end else begin
               owner_nx      = pick;
               grant_nx      = N'(1) << pick;
               cnt_target_nx = pick_ticks;
               cnt_nx        = '0;
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
               abort_nx      = 1'b0;
`endif
               state_nx      = (pick_ticks == '0) ? S_DONE : S_START;
            end
         end
         S_START: state_nx = S_WAIT;
         S_WAIT: begin
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
            if (owner_dropped) begin
               abort_nx = 1'b1;
               state_nx = S_STOP;
            end else
`endif
            if (tmr_irq) state_nx = S_ACK;
         end
         S_ACK: begin
            cnt_nx   = cnt + 1'b1;
            state_nx = S_GAP;
         end
         S_GAP: begin
            // irq is still high here from the timeout just cleared, so it is not looked at.
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
            if (owner_dropped) begin
               abort_nx = 1'b1;
               state_nx = S_STOP;
            end else
`endif
            state_nx = (cnt == cnt_target) ? S_STOP : S_WAIT;
         end
         S_STOP: state_nx = S_DONE;
         S_DONE: begin
            grant_nx  = '0;
            rr_ptr_nx = PW'((int'(owner) + 1) % N);
            state_nx  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Bus and pulse outputs are registered from the state being entered,
   // so each write lands exactly in its START/ACK/STOP cycle.
   always_comb begin
      chipselect_nx = 1'b0;
      write_n_nx    = 1'b1;
      address_nx    = '0;
      writedata_nx  = '0;
      done_nx       = '0;
      case (state_nx)
         S_START: begin
            chipselect_nx = 1'b1;
            write_n_nx    = 1'b0;
            address_nx    = REG_CONTROL;
            writedata_nx  = CTRL_START;
         end
         S_ACK: begin
            chipselect_nx = 1'b1;
            write_n_nx    = 1'b0;
            address_nx    = REG_STATUS;
            writedata_nx  = STATUS_CLR;
         end
         S_STOP: begin
            chipselect_nx = 1'b1;
            write_n_nx    = 1'b0;
            address_nx    = REG_CONTROL;
            writedata_nx  = CTRL_STOP;
         end
         default: ;
      endcase
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
      cancelled_nx = (state_nx == S_DONE) && abort_nx;
      if ((state_nx == S_DONE) && !abort_nx) done_nx = grant_nx;
`else
      if (state_nx == S_DONE) done_nx = grant_nx;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         rr_ptr         <= '0;
         owner          <= '0;
         cnt            <= '0;
         cnt_target     <= '0;
         grant          <= '0;
         done           <= '0;
         busy           <= 1'b0;
         tmr_chipselect <= 1'b0;
         tmr_write_n    <= 1'b1;
         tmr_address    <= '0;
         tmr_writedata  <= '0;
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
         abort          <= 1'b0;
         cancelled      <= 1'b0;
`endif
      end else begin
         state          <= state_nx;
         rr_ptr         <= rr_ptr_nx;
         owner          <= owner_nx;
         cnt            <= cnt_nx;
         cnt_target     <= cnt_target_nx;
         grant          <= grant_nx;
         done           <= done_nx;
         busy           <= (state_nx != S_IDLE);
         tmr_chipselect <= chipselect_nx;
         tmr_write_n    <= write_n_nx;
         tmr_address    <= address_nx;
         tmr_writedata  <= writedata_nx;
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
         abort          <= abort_nx;
         cancelled      <= cancelled_nx;
`endif
      end
   end

endmodule

// File: tb/tb_timer_share_sched.sv
// Bench for timer_share_sched: behavioural timer model, random requesters and a transaction-level scoreboard.
module tb_timer_share_sched;

   localparam int N  = 4;
   localparam int TW = 8;
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
   localparam bit CANCEL = 1'b1;
`else
   localparam bit CANCEL = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req;
   logic [N*TW-1:0] ticks;
   logic [N-1:0]    grant;
   logic [N-1:0]    done;
   logic            busy;
   logic [2:0]      tmr_address;
   logic            tmr_chipselect;
   logic            tmr_write_n;
   logic [15:0]     tmr_writedata;
   logic            tmr_irq;
   logic            cancel_seen;

`ifdef TIMER_SHARE_SCHED_CANCEL_EN
   logic            cancelled;
   assign cancel_seen = cancelled;
`else
   assign cancel_seen = 1'b0;
`endif

   timer_share_sched #(.N(N), .TW(TW)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .req            (req),
      .ticks          (ticks),
      .grant          (grant),
      .done           (done),
      .busy           (busy),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
      .cancelled      (cancelled),
`endif
      .tmr_irq        (tmr_irq)
   );

   always #5 clk = ~clk;

   // Interval timer: START/ACK (re)load the period, timeout raises irq,
   // a status write drops irq one cycle after the write.
   int   tmr_period;
   int   tmr_cd;
   logic tmr_run;
   logic tmr_clr;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr_irq <= 1'b0;
         tmr_run <= 1'b0;
         tmr_cd  <= 0;
         tmr_clr <= 1'b0;
      end else begin
         tmr_clr <= 1'b0;
         if (tmr_clr) tmr_irq <= 1'b0;
         if (tmr_chipselect && !tmr_write_n) begin
            if (tmr_address == 3'd0) begin
               tmr_clr <= 1'b1;
               tmr_cd  <= tmr_period;
            end else if (tmr_address == 3'd1 && tmr_writedata[2]) begin
               tmr_run <= 1'b1;
               tmr_cd  <= tmr_period;
            end else if (tmr_address == 3'd1 && tmr_writedata[3]) begin
               tmr_run <= 1'b0;
            end
         end else if (tmr_run) begin
            if (tmr_cd <= 1) begin
               tmr_irq <= 1'b1;
               tmr_cd  <= tmr_period;
            end else begin
               tmr_cd <= tmr_cd - 1;
            end
         end
      end
   end

   // Requests as seen at the most recent rising edge (what arbitration used).
   logic [N-1:0] req_at_edge;
   always @(posedge clk) req_at_edge <= req;

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard state
   bit in_service;
   bit dropped;
   int owner_m;
   int exp_k;
   int n_start, n_ack, n_stop;
   int mptr;
   int services;
   int tick_val [N];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed === expected) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
   endtask

   task automatic monitor();
      logic [N-1:0] exp_g;
      int ea, ed, w;
      if (in_service) begin
         exp_g = N'(1) << owner_m;
         checkOutput("grant_hold", 32'(grant), 32'(exp_g));
         checkOutput("busy", 32'(busy), 32'd1);
      end else if (grant != '0) begin
         w = -1;
         for (int j = 0; j < N; j++) begin
            int idx;
            idx = (mptr + j) % N;
            if (w < 0 && req_at_edge[idx]) w = idx;
         end
         if (w < 0) begin
            checkOutput("arb_no_req", 32'(grant), 32'd0);
         end else begin
            exp_g = N'(1) << w;
            checkOutput("arb_grant", 32'(grant), 32'(exp_g));
            in_service = 1'b1;
            dropped    = 1'b0;
            owner_m    = w;
            exp_k      = tick_val[w];
            n_start    = 0;
            n_ack      = 0;
            n_stop     = 0;
         end
      end

      if (tmr_chipselect || !tmr_write_n) begin
         if (!in_service) begin
            checkOutput("stray_write", 32'({tmr_chipselect, tmr_write_n}), 32'd1);
         end else begin
            if (n_start == 0) begin
               ea = 1; ed = 16'h0007;
            end else if (n_ack < exp_k && !(CANCEL && dropped)) begin
               ea = 0; ed = 16'h0000;
            end else begin
               ea = 1; ed = 16'h0008;
            end
            checkOutput("wr_strobe", 32'({tmr_chipselect, tmr_write_n}), 32'd2);
            checkOutput("wr_addr", 32'(tmr_address), 32'(ea));
            checkOutput("wr_data", 32'(tmr_writedata), 32'(ed));
            if (tmr_address == 3'd1 && tmr_writedata == 16'h0007) n_start++;
            else if (tmr_address == 3'd0) n_ack++;
            else if (tmr_address == 3'd1 && tmr_writedata == 16'h0008) n_stop++;
         end
      end

      if (in_service && (done != '0 || cancel_seen)) begin
         exp_g = N'(1) << owner_m;
         if (CANCEL && dropped) begin
            checkOutput("cancel_done", 32'(done), 32'd0);
            checkOutput("cancel_pulse", 32'(cancel_seen), 32'd1);
            checkOutput("cancel_stop", 32'(n_stop), 32'd1);
         end else begin
            checkOutput("done", 32'(done), 32'(exp_g));
`ifdef TIMER_SHARE_SCHED_CANCEL_EN
            checkOutput("no_cancel", 32'(cancel_seen), 32'd0);
`endif
            checkOutput("n_start", 32'(n_start), 32'(exp_k > 0));
            checkOutput("n_ack", 32'(n_ack), 32'(exp_k));
            checkOutput("n_stop", 32'(n_stop), 32'(exp_k > 0));
         end
         in_service = 1'b0;
         mptr       = (owner_m + 1) % N;
         services++;
      end else if (done != '0) begin
         checkOutput("spurious_done", 32'(done), 32'd0);
      end
   endtask

   task automatic set_req(input int i, input int t);
      tick_val[i]      = t;
      ticks[i*TW +: TW] = TW'(t);
      req[i]           = 1'b1;
   endtask

   // One cycle: score the outputs, then drive requesters.
   // mode 0 holds req, 1 random arrivals with drop on done, 2 drop on done only.
   task automatic applyStimulus(input int mode);
      @(negedge clk);
      monitor();
      for (int i = 0; i < N; i++) begin
         if (mode != 0 && req[i] && done[i]) begin
            req[i] = 1'b0;
         end else if (mode == 1 && !req[i] && $urandom_range(0, 7) == 0) begin
            set_req(i, int'($urandom_range(0, 4)));
         end
      end
   endtask

   task automatic wait_services(input int target, input int budget, input int mode);
      int k;
      k = 0;
      while (services < target && k < budget) begin
         applyStimulus(mode);
         k++;
      end
      if (services < target) checkOutput("service_timeout", 32'(services), 32'(target));
   endtask

   task automatic wait_grant(input int budget);
      int k;
      k = 0;
      while (!in_service && k < budget) begin
         applyStimulus(2);
         k++;
      end
      if (!in_service) checkOutput("grant_timeout", 32'(in_service), 32'd1);
   endtask

   initial begin
      int k;
      reset_n    = 1'b0;
      req        = '0;
      ticks      = '0;
      tmr_period = 3;
      in_service = 1'b0;
      dropped    = 1'b0;
      owner_m    = 0;
      exp_k      = 0;
      n_start    = 0;
      n_ack      = 0;
      n_stop     = 0;
      mptr       = 0;
      services   = 0;
      for (int i = 0; i < N; i++) tick_val[i] = 0;

      repeat (2) @(negedge clk);
      checkOutput("rst_grant", 32'(grant), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_cs", 32'(tmr_chipselect), 32'd0);
      checkOutput("rst_wr_n", 32'(tmr_write_n), 32'd1);
      checkOutput("rst_addr", 32'(tmr_address), 32'd0);
      checkOutput("rst_wdata", 32'(tmr_writedata), 32'd0);
      reset_n = 1'b1;

      // Round robin with everyone requesting one tick
      for (int i = 0; i < N; i++) set_req(i, 1);
      wait_services(services + 5, 300, 0);
      req = '0;
      repeat (3) applyStimulus(2);

      // Single request, three ticks, slow timer
      tmr_period = 20;
      set_req(0, 3);
      wait_services(services + 1, 400, 2);
      repeat (3) applyStimulus(2);

      // Zero ticks: no timer traffic at all
      set_req(1, 0);
      wait_services(services + 1, 20, 2);
      repeat (3) applyStimulus(2);

      // Owner drops its request right after the grant
      tmr_period = 6;
      set_req(0, 2);
      wait_grant(20);
      applyStimulus(2);
      req[0]  = 1'b0;
      dropped = 1'b1;
      wait_services(services + 1, 200, 2);
      repeat (3) applyStimulus(2);

      // Largest count the tick field can hold
      tmr_period = 2;
      set_req(3, 255);
      wait_services(services + 1, 3000, 2);
      repeat (3) applyStimulus(2);

      // Random traffic, then drain
      tmr_period = int'($urandom_range(2, 6));
      repeat (800) applyStimulus(1);
      k = 0;
      while ((req != '0 || in_service) && k < 1000) begin
         applyStimulus(2);
         k++;
      end
      if (req != '0 || in_service) checkOutput("drain_timeout", 32'(req), 32'd0);
      repeat (3) applyStimulus(2);

      // Asynchronous reset while waiting on the timer
      tmr_period = 20;
      set_req(2, 5);
      wait_grant(20);
      repeat (3) applyStimulus(2);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("arst_grant", 32'(grant), 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_cs", 32'(tmr_chipselect), 32'd0);
      checkOutput("arst_wr_n", 32'(tmr_write_n), 32'd1);
      checkOutput("arst_done", 32'(done), 32'd0);
      req        = '0;
      in_service = 1'b0;
      mptr       = 0;
      repeat (2) @(negedge clk);
      reset_n    = 1'b1;
      tmr_period = 3;
      set_req(1, 1);
      wait_services(services + 1, 100, 2);
      repeat (3) applyStimulus(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
